forward_hazard_unit: RTL
========================

Name: forward_hazard_unit

Overview:
- Producer side of the execute stage's operand and flag bypass.
- Tracks destination-register and CCR-write tags of in-flight instructions in EX, MEM and WB.
- Emits the registered ALU operand-mux selects (ExMux3Select/ExMux4Select) and CCR-mux select consumed by execute.
- Detects load-use hazards and stalls the register-read (RR) stage for one cycle.

Parameters:
- REG_AW, 3, register-address width (8 GPRs).
- SEL_W, 3, operand-select width (matches 8-input operand mux).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rr_valid  in  1  instruction present in RR stage.
- rr_rs1  in  REG_AW  source reg feeding ALU input 1.
- rr_rs2  in  REG_AW  source reg feeding ALU input 2.
- rr_use1  in  1  rs1 actually read.
- rr_use2  in  1  rs2 actually read.
- rr_rd  in  REG_AW  destination reg.
- rr_rd_wr  in  1  instruction writes rd.
- rr_is_load  in  1  rd value comes from data memory (LW/LM).
- rr_ccr_use  in  1  instruction reads flags (ADC/ADZ/NDC/NDZ).
- rr_ccr_wr  in  1  instruction may write CCR.
- stall_in  in  1  external freeze of whole pipe.
- flush  in  1  kill instruction leaving RR (branch redirect).
- stall_out  out  1  hold RR/IF, insert bubble into EX.
- ex_sel1  out  SEL_W  ALU input 1 forward select.
- ex_sel2  out  SEL_W  ALU input 2 forward select.
- ccr_sel  out  2  CCR mux select.

Behaviour:
- Tag slots EX, MEM, WB; each holds valid, rd, rd_wr, is_load, ccr_wr.
- Reset (reset==0, async): all slot valids 0; ex_sel1=ex_sel2=0, ccr_sel=0. stall_out is then 0 by construction.
- Operand select codes:
  - 0: register file.
  - 1: MEM-stage ALU result (producer was in EX).
  - 2: WB-stage value (producer was in MEM).
  - 3: retire latch (producer was in WB; RF write lands at the same edge as the read).
  - 4-7: reserved, never driven.
- CCR select codes: 0 = CCR register, 1 = MEM-stage flags, 2 = WB-stage flags, 3 = retire-latch flags.
- Match rule for operand n: valid && rd_wr && rd==rr_rsn && rr_usen. Youngest match wins (EX slot > MEM > WB). No match gives 0.
- CCR match rule: valid && ccr_wr && rr_ccr_use. Same youngest-first priority.
- Hazard = rr_valid && !flush && EX.valid && EX.is_load && EX.rd_wr && ((rr_use1 && rr_rs1==EX.rd) || (rr_use2 && rr_rs2==EX.rd)). stall_out = hazard, combinational, same cycle.
- Edge update, in priority order:
  - stall_in=1, flush=0: all slots and selects hold.
  - flush=1 (wins over stall_in): EX slot invalidated, selects cleared to 0. MEM/WB advance if stall_in=0, otherwise hold.
  - hazard: WB<=MEM, MEM<=EX, EX<=bubble, selects<=0. On the next cycle the load sits in MEM, so the re-evaluated select is 2.
  - normal: WB<=MEM, MEM<=EX, EX<=RR tags (valid=rr_valid), selects<=computed codes. An invalid RR instruction gives selects 0.
- Latency: select codes are registered, valid in the cycle the instruction is in EX. Hazard-stall penalty is exactly 1 cycle.
- A load producer in MEM or WB never stalls.
- A single CCR producer with no GPR write still drives ccr_sel.
- Reset mid-operation clears all tags; there is no partial retention.

Decomposition:
- Shared package: select-code constants (SEL_RF=0, SEL_MEM=1, SEL_WB=2, SEL_RET=3; CCR_SEL_REG..CCR_SEL_RET), REG_AW, and the slot-tag field layout.
- One natural sub-module, fwd_tag_slot: a single pipeline tag register with hold/bubble/load controls, instantiated three times.
- Priority compare stays in the top module.

Test Plan:
- ADD r1 then ADD r2=r1+r3 back-to-back: second instruction's EX cycle shows ex_sel1=1, ex_sel2=0, stall_out never 1.
- Producer r4, two independent instructions, then consumer of r4 on rs2: ex_sel2=3 in the consumer's EX cycle. With one independent instruction in between instead: ex_sel2=2.
- LW r5 followed by ADD using r5 as rs1: stall_out=1 for exactly one cycle and EX gets a bubble (selects 0). Next cycle ex_sel1=2. Total 1-cycle penalty.
- ADD r1 (EX) and ADD r1 (MEM) both in flight, consumer reads r1: select=1 (youngest wins).
- Same LW-use pair with flush=1 in the hazard cycle: stall_out=0, EX slot invalid next cycle, selects 0.
- ADD (ccr_wr=1) then ADC: ccr_sel=1. Assert stall_in for 3 cycles between them: selects and slots hold. Release: ccr_sel=1. Assert reset low mid-stream: all outputs 0 immediately.

Source files
------------

// File: rtl/forward_hazard_unit_pkg.sv
// forward_hazard_unit_pkg
//   Shared definitions for the execute-stage operand/flag bypass producer:
//   select-code constants, the per-stage tag layout and small helpers for
//   the match / youngest-first priority logic.
package forward_hazard_unit_pkg;

  localparam int REG_AW = 3;

  // ALU operand mux select codes (codes 4-7 of the 8-input mux are unused)
  localparam logic [1:0] SEL_RF  = 2'd0;  // register file
  localparam logic [1:0] SEL_MEM = 2'd1;  // producer was in EX
  localparam logic [1:0] SEL_WB  = 2'd2;  // producer was in MEM
  localparam logic [1:0] SEL_RET = 2'd3;  // producer was in WB (retire latch)

  // CCR mux select codes
  localparam logic [1:0] CCR_SEL_REG = 2'd0;
  localparam logic [1:0] CCR_SEL_MEM = 2'd1;
  localparam logic [1:0] CCR_SEL_WB  = 2'd2;
  localparam logic [1:0] CCR_SEL_RET = 2'd3;

  // Tag carried alongside an instruction through EX / MEM / WB
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              rd_wr;
    logic              is_load;
    logic              ccr_wr;
  } fwd_tag_t;

  localparam fwd_tag_t TAG_BUBBLE = '0;

  function automatic logic gpr_hit(input fwd_tag_t t, input logic [REG_AW-1:0] rs,
                                   input logic use_rs);
    return use_rs & t.valid & t.rd_wr & (t.rd == rs);
  endfunction

  function automatic logic ccr_hit(input fwd_tag_t t, input logic use_ccr);
    return use_ccr & t.valid & t.ccr_wr;
  endfunction

  // Youngest producer wins: EX slot, then MEM, then WB.
  function automatic logic [1:0] pick_sel(input logic hit_ex, input logic hit_mem,
                                          input logic hit_wb);
    if (hit_ex)       return SEL_MEM;
    else if (hit_mem) return SEL_WB;
    else if (hit_wb)  return SEL_RET;
    else              return SEL_RF;
  endfunction

  function automatic logic [1:0] pick_ccr(input logic hit_ex, input logic hit_mem,
                                          input logic hit_wb);
    if (hit_ex)       return CCR_SEL_MEM;
    else if (hit_mem) return CCR_SEL_WB;
    else if (hit_wb)  return CCR_SEL_RET;
    else              return CCR_SEL_REG;
  endfunction

endpackage

// File: rtl/fwd_tag_slot.sv
// fwd_tag_slot
//   One pipeline tag register.
//   Ports: clk, reset (async, active low), hold (keep contents),
//          bubble (load an invalid tag, overrides hold), tag_in (next tag),
//          tag_q (registered tag).
module fwd_tag_slot
  import forward_hazard_unit_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     hold,
  input  logic     bubble,
  input  fwd_tag_t tag_in,
  output fwd_tag_t tag_q
);

  fwd_tag_t tag_d;

  always_comb begin
    tag_d = tag_q;
    if (bubble)     tag_d = TAG_BUBBLE;
    else if (!hold) tag_d = tag_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tag_q <= TAG_BUBBLE;
    else        tag_q <= tag_d;
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit
//   Producer side of the execute-stage operand and CCR bypass. Tracks the
//   destination / CCR-write tags of instructions in EX, MEM and WB, registers
//   the forward selects for the instruction leaving RR, and stalls RR for one
//   cycle on a load-use dependency against the instruction in EX.
//   Ports:
//     clk, reset          clock, async active-low reset
//     rr_*                decoded fields of the instruction in RR
//     stall_in            freeze the whole pipe
//     flush               kill the instruction leaving RR
//     stall_out           hold RR/IF, bubble into EX (combinational)
//     ex_sel1/ex_sel2     registered ALU operand forward selects
//     ccr_sel             registered CCR forward select
module forward_hazard_unit #(
  parameter int REG_AW = 3,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rr_valid,
  input  logic [REG_AW-1:0] rr_rs1,
  input  logic [REG_AW-1:0] rr_rs2,
  input  logic              rr_use1,
  input  logic              rr_use2,
  input  logic [REG_AW-1:0] rr_rd,
  input  logic              rr_rd_wr,
  input  logic              rr_is_load,
  input  logic              rr_ccr_use,
  input  logic              rr_ccr_wr,
  input  logic              stall_in,
  input  logic              flush,
  output logic              stall_out,
  output logic [SEL_W-1:0]  ex_sel1,
  output logic [SEL_W-1:0]  ex_sel2,
  output logic [1:0]        ccr_sel
);

  import forward_hazard_unit_pkg::*;

  fwd_tag_t rr_tag, ex_tag, mem_tag, wb_tag;

  logic       hazard;
  logic       ex_kill;
  logic [1:0] code1, code2, code_ccr;

  logic [SEL_W-1:0] sel1_d, sel1_q;
  logic [SEL_W-1:0] sel2_d, sel2_q;
  logic [1:0]       ccr_sel_d, ccr_sel_q;

  always_comb begin
    rr_tag         = TAG_BUBBLE;
    rr_tag.valid   = rr_valid;
    rr_tag.rd      = rr_rd;
    rr_tag.rd_wr   = rr_rd_wr;
    rr_tag.is_load = rr_is_load;
    rr_tag.ccr_wr  = rr_ccr_wr;
  end

  // Only a load still in EX can't be bypassed in time; from MEM onward the
  // WB-stage value is available.
  assign hazard = rr_valid & ~flush & ex_tag.is_load &
                  (gpr_hit(ex_tag, rr_rs1, rr_use1) | gpr_hit(ex_tag, rr_rs2, rr_use2));
  assign stall_out = hazard;

  // EX receives a bubble on flush (even when frozen) or on a load-use stall
  // that actually advances the pipe.
  assign ex_kill = flush | (hazard & ~stall_in);

  fwd_tag_slot u_ex_slot (
    .clk    (clk),
    .reset  (reset),
    .hold   (stall_in),
    .bubble (ex_kill),
    .tag_in (rr_tag),
    .tag_q  (ex_tag)
  );

  fwd_tag_slot u_mem_slot (
    .clk    (clk),
    .reset  (reset),
    .hold   (stall_in),
    .bubble (1'b0),
    .tag_in (ex_tag),
    .tag_q  (mem_tag)
  );

  fwd_tag_slot u_wb_slot (
    .clk    (clk),
    .reset  (reset),
    .hold   (stall_in),
    .bubble (1'b0),
    .tag_in (mem_tag),
    .tag_q  (wb_tag)
  );

  always_comb begin
    code1 = SEL_RF;
    code2 = SEL_RF;
    code_ccr = CCR_SEL_REG;
    if (rr_valid) begin
      code1 = pick_sel(gpr_hit(ex_tag, rr_rs1, rr_use1),
                       gpr_hit(mem_tag, rr_rs1, rr_use1),
                       gpr_hit(wb_tag, rr_rs1, rr_use1));
      code2 = pick_sel(gpr_hit(ex_tag, rr_rs2, rr_use2),
                       gpr_hit(mem_tag, rr_rs2, rr_use2),
                       gpr_hit(wb_tag, rr_rs2, rr_use2));
      code_ccr = pick_ccr(ccr_hit(ex_tag, rr_ccr_use),
                          ccr_hit(mem_tag, rr_ccr_use),
                          ccr_hit(wb_tag, rr_ccr_use));
    end
  end

  // Select update mirrors the EX slot: cleared with a bubble, held on freeze.
  always_comb begin
    sel1_d    = sel1_q;
    sel2_d    = sel2_q;
    ccr_sel_d = ccr_sel_q;
    if (ex_kill) begin
      sel1_d    = '0;
      sel2_d    = '0;
      ccr_sel_d = CCR_SEL_REG;
    end else if (!stall_in) begin
      sel1_d    = SEL_W'(code1);
      sel2_d    = SEL_W'(code2);
      ccr_sel_d = code_ccr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel1_q    <= '0;
      sel2_q    <= '0;
      ccr_sel_q <= CCR_SEL_REG;
    end else begin
      sel1_q    <= sel1_d;
      sel2_q    <= sel2_d;
      ccr_sel_q <= ccr_sel_d;
    end
  end

  assign ex_sel1 = sel1_q;
  assign ex_sel2 = sel2_q;
  assign ccr_sel = ccr_sel_q;

  // Load flag of the oldest slot has no consumer.
  logic unused_wb_load;
  assign unused_wb_load = wb_tag.is_load;

endmodule
